rv32i_seq_ctrl: RTL
===================

# rv32i_seq_ctrl

Multicycle sequencing controller for the RV32I core. Owns the PC, fetches one instruction at a time over a req/ack instruction port, and decodes the latched `Rv32i` word into datapath controls (ALU op, operand select, immediate, write-back select, register-file write enable). Drives the data-memory handshake for loads and stores. Sits between instruction/data memories and the ALU/register-file datapath.

## Interface

Parameters:

- `RESET_PC`, 32'h0000_0000, PC value loaded on reset.

Ports:

- `clk` input 1: single clock, all state on rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `imem_req` output 1: instruction fetch request.
- `imem_addr` output 32: fetch address, equals `pc`.
- `imem_ack` input 1: fetch accepted and `imem_rdata` valid this cycle.
- `imem_rdata` input 32: fetched word, typed `Rv32i`.
- `dmem_req` output 1: data access request.
- `dmem_we` output 1: 1 = store.
- `dmem_be` output 4: byte enables.
- `dmem_ack` input 1: data access complete.
- `dmem_addr_lo` input 2: low bits of datapath-computed address.
- `br_taken` input 1: datapath branch/jump resolves taken (valid in EXEC).
- `br_target` input 32: taken target (valid in EXEC).
- `pc` output 32: current PC.
- `instr` output 32: latched instruction (`Rv32i`).
- `alu_op` output 4: `alu_op_t`.
- `alu_src_imm` output 1: operand B is `imm`.
- `imm` output 32: sign-extended immediate for the instruction's format.
- `wb_sel` output 2: `wb_sel_t` (ALU, MEM, PC4, IMM).
- `rf_we` output 1: register-file write strobe.
- `halted` output 1: core stopped.
- `trap` output 1: stopped due to fault.

## Operation

States: FETCH, DECODE, EXEC, MEM, WB, HALT.

- FETCH: `imem_req`=1. Holds while `imem_ack`=0. On ack, latch `instr`, go DECODE.
- DECODE: `imm`, `alu_op`, `alu_src_imm`, and `wb_sel` become valid from `instr` and stay registered until the next DECODE. Next state:
  - SYSTEM (ECALL/EBREAK): go HALT.
  - illegal: see Configuration.
  - otherwise: go EXEC.
- EXEC: PC update at exit: `pc` <= `br_taken` ? `br_target` : `pc`+4.
  - Branches go FETCH.
  - Loads and stores go MEM.
  - FENCE goes FETCH (no-op).
  - All other instructions go WB.
- MEM: `dmem_req`=1, `dmem_we`=1 for stores. `dmem_be` is derived from funct3 and `dmem_addr_lo`:
  - B: one-hot shifted.
  - H: 4'b0011 or 4'b1100.
  - W: 4'hF.
  - Holds while `dmem_ack`=0. On ack, stores go FETCH and loads go WB.
- WB: `rf_we`=1 for exactly one cycle unless rd==0. Go FETCH.
- HALT: all requests 0, `halted`=1. Exits only on reset.

Rules:

- PC arithmetic is modulo 2^32; 32'hFFFF_FFFC+4 wraps to 0.
- JAL/JALR use `wb_sel`=PC4, where the written value is the pre-update PC+4.
- LUI uses `wb_sel`=IMM. AUIPC uses ALU with `imm`.

## Timing

- Reset values: `pc`=`RESET_PC`, state FETCH, `instr`=0, `imm`=0, `alu_op`=ADD, `wb_sel`=ALU.
- Also zero at reset: `imem_req`, `dmem_req`, `dmem_we`, `dmem_be`, `rf_we`, `halted`, `trap`.
- `imem_req` rises in the first cycle after `rst_n` deasserts.
- Same-cycle ack is allowed on both ports; requests drop the cycle after ack.
- Zero-wait latency: ALU/LUI/JAL = 4 cycles, load = 5, store = 4, branch = 3.
- Request outputs and `imem_addr` are stable while waiting for ack.
- Reset asserted mid-access drops `imem_req`/`dmem_req` immediately (asynchronously); the pending ack is ignored.
- `rf_we` is never asserted outside WB.

## Configuration

`RV32I_SEQ_TRAP_EN`

- Defined:
  - Unknown opcode goes HALT with `trap`=1.
  - Misaligned H/W data access (H at addr_lo 1/3; W at nonzero) is detected in MEM before `dmem_req` and goes HALT with `trap`=1.
  - A taken `br_target` with bits[1:0]≠0 goes HALT with `trap`=1, and `pc` is not updated.
- Undefined:
  - Unknown opcodes execute as NOP (DECODE→FETCH, pc+4).
  - Misaligned accesses use aligned-down `dmem_be`.
  - Misaligned targets are used with bits[1:0] forced to 0.
  - `trap` is tied to 0.

## Structure

- Shared package `Rv32i_pkg` holds:
  - opcode constants (OP, OP_IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC, MISC_MEM, SYSTEM);
  - `seq_state_t`, `alu_op_t`, and `wb_sel_t` enums.
- Sub-module `rv32i_imm_gen`: combinational; `Rv32i` in, 32-bit sign-extended immediate out, selecting the I/S/B/U/J format by opcode. It is registered in DECODE.

## Test plan

- Reset, then fetch `addi x1,x0,5` (32'h00500093) with ack same cycle → at WB: `rf_we`=1, `alu_src_imm`=1, `imm`=5, `wb_sel`=ALU; `pc`=4; next `imem_req` at cycle 5.
- `imem_ack` delayed 3 cycles → `imem_req` and `imem_addr` held constant for 4 cycles; `instr` latched only on ack.
- `sb` with `dmem_addr_lo`=2 → `dmem_be`=4'b0100, `dmem_we`=1; no `rf_we`.
- `lw` with `dmem_ack` after 2 cycles → `wb_sel`=MEM and `rf_we` one cycle after ack.
- `beq` with `br_taken`=1, `br_target`=32'h100 → `pc`=32'h100 after 3 cycles.
- `addi x0,x0,0` → no `rf_we`. Opcode 7'b1111111 → with the macro, `halted`=`trap`=1; without it, `pc`+4.
- Reset mid-MEM → `dmem_req` drops immediately and `pc`=`RESET_PC`.

Source files
------------

// File: rtl/rv32i_seq_ctrl_pkg.sv
// Shared RV32I opcode constants, sequencer/ALU/write-back enums and small decode helpers.
package Rv32i_pkg;

    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
    } seq_state_t;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
    } alu_op_t;

    typedef enum logic [1:0] {
        WB_ALU, WB_MEM, WB_PC4, WB_IMM
    } wb_sel_t;

    function automatic logic opcode_known(input logic [6:0] opc);
        case (opc)
            OPC_OP, OPC_OP_IMM, OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_JAL,
            OPC_JALR, OPC_LUI, OPC_AUIPC, OPC_MISC_MEM, OPC_SYSTEM: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Only register-register ADD/SUB is split by funct7; OP_IMM shifts use bit 30 for SRAI.
    function automatic alu_op_t alu_op_of(input logic [6:0] opc, input logic [2:0] f3,
                                          input logic f7b5);
        alu_op_t op;
        op = ALU_ADD;
        if (opc == OPC_BRANCH) begin
            op = ALU_SUB;
        end else if (opc == OPC_OP || opc == OPC_OP_IMM) begin
            case (f3)
                3'b000:  op = (opc == OPC_OP && f7b5) ? ALU_SUB : ALU_ADD;
                3'b001:  op = ALU_SLL;
                3'b010:  op = ALU_SLT;
                3'b011:  op = ALU_SLTU;
                3'b100:  op = ALU_XOR;
                3'b101:  op = f7b5 ? ALU_SRA : ALU_SRL;
                3'b110:  op = ALU_OR;
                default: op = ALU_AND;
            endcase
        end
        return op;
    endfunction

    function automatic wb_sel_t wb_sel_of(input logic [6:0] opc);
        case (opc)
            OPC_LOAD:          return WB_MEM;
            OPC_JAL, OPC_JALR: return WB_PC4;
            OPC_LUI:           return WB_IMM;
            default:           return WB_ALU;
        endcase
    endfunction

endpackage

// File: rtl/rv32i_seq_ctrl_imm_gen.sv
// Combinational immediate generator: picks the I/S/B/U/J format from the opcode and sign-extends.
module rv32i_imm_gen
    import Rv32i_pkg::*;
(
    input  logic [31:0] instr,
    output logic [31:0] imm
);

    always_comb begin
        imm = 32'h0;
        case (instr[6:0])
            OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_MISC_MEM, OPC_SYSTEM:
                imm = {{20{instr[31]}}, instr[31:20]};
            OPC_STORE:
                imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            OPC_BRANCH:
                imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            OPC_LUI, OPC_AUIPC:
                imm = {instr[31:12], 12'h000};
            OPC_JAL:
                imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default:
                imm = 32'h0;
        endcase
    end

endmodule

// File: rtl/rv32i_seq_ctrl.sv
// Multicycle RV32I sequencer: FETCH/DECODE/EXEC/MEM/WB/HALT with PC, decode registers and memory handshakes.
// Optional fault trapping (unknown opcode, misaligned data/target) is enabled by RV32I_SEQ_TRAP_EN.
module rv32i_seq_ctrl
    import Rv32i_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ack,
    input  logic [1:0]  dmem_addr_lo,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    output logic [31:0] pc,
    output logic [31:0] instr,
    output logic [3:0]  alu_op,
    output logic        alu_src_imm,
    output logic [31:0] imm,
    output logic [1:0]  wb_sel,
    output logic        rf_we,
    output logic        halted,
    output logic        trap
);

`ifdef RV32I_SEQ_TRAP_EN
    localparam bit TrapEn = 1'b1;
`else
    localparam bit TrapEn = 1'b0;
`endif

    seq_state_t  state_q, state_d;
    logic        run_q, run_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] imm_q, imm_d;
    alu_op_t     alu_op_q, alu_op_d;
    logic        alu_src_imm_q, alu_src_imm_d;
    wb_sel_t     wb_sel_q, wb_sel_d;
    logic        trap_q, trap_d;

    logic [31:0] imm_w;
    logic [6:0]  opc;
    logic [1:0]  size_lo;
    logic [3:0]  be_w;
    logic        mis_data;
    logic        mem_go;

    assign opc     = instr_q[6:0];
    assign size_lo = instr_q[13:12];

    rv32i_imm_gen u_imm_gen (
        .instr (instr_q),
        .imm   (imm_w)
    );

    // Misaligned H/W accesses fall back to the aligned-down lane mask.
    always_comb begin
        be_w = 4'hF;
        case (size_lo)
            2'b00:   be_w = 4'b0001 << dmem_addr_lo;
            2'b01:   be_w = dmem_addr_lo[1] ? 4'b1100 : 4'b0011;
            default: be_w = 4'hF;
        endcase
    end

    assign mis_data = (size_lo == 2'b01 && dmem_addr_lo[0]) ||
                      (size_lo[1] && dmem_addr_lo != 2'b00);
    assign mem_go   = (state_q == S_MEM) && !(TrapEn && mis_data);

    always_comb begin
        state_d       = state_q;
        run_d         = 1'b1;
        pc_d          = pc_q;
        instr_d       = instr_q;
        imm_d         = imm_q;
        alu_op_d      = alu_op_q;
        alu_src_imm_d = alu_src_imm_q;
        wb_sel_d      = wb_sel_q;
        trap_d        = trap_q;
        case (state_q)
            S_FETCH: begin
                if (run_q && imem_ack) begin
                    instr_d = imem_rdata;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                imm_d         = imm_w;
                alu_op_d      = alu_op_of(opc, instr_q[14:12], instr_q[30]);
                alu_src_imm_d = !(opc == OPC_OP || opc == OPC_BRANCH);
                wb_sel_d      = wb_sel_of(opc);
                if (opc == OPC_SYSTEM) begin
                    state_d = S_HALT;
                end else if (!opcode_known(opc)) begin
                    if (TrapEn) begin
                        state_d = S_HALT;
                        trap_d  = 1'b1;
                    end else begin
                        state_d = S_FETCH;
                        pc_d    = pc_q + 32'd4;
                    end
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (TrapEn && br_taken && br_target[1:0] != 2'b00) begin
                    state_d = S_HALT;
                    trap_d  = 1'b1;
                end else begin
                    pc_d = br_taken ? (br_target & 32'hFFFF_FFFC) : pc_q + 32'd4;
                    case (opc)
                        OPC_BRANCH, OPC_MISC_MEM: state_d = S_FETCH;
                        OPC_LOAD, OPC_STORE:      state_d = S_MEM;
                        default:                  state_d = S_WB;
                    endcase
                end
            end
            S_MEM: begin
                if (TrapEn && mis_data) begin
                    state_d = S_HALT;
                    trap_d  = 1'b1;
                end else if (dmem_ack) begin
                    state_d = (opc == OPC_STORE) ? S_FETCH : S_WB;
                end
            end
            S_WB:    state_d = S_FETCH;
            S_HALT:  state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_FETCH;
            run_q         <= 1'b0;
            pc_q          <= RESET_PC;
            instr_q       <= 32'h0;
            imm_q         <= 32'h0;
            alu_op_q      <= ALU_ADD;
            alu_src_imm_q <= 1'b0;
            wb_sel_q      <= WB_ALU;
            trap_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            run_q         <= run_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            imm_q         <= imm_d;
            alu_op_q      <= alu_op_d;
            alu_src_imm_q <= alu_src_imm_d;
            wb_sel_q      <= wb_sel_d;
            trap_q        <= trap_d;
        end
    end

    // run_q keeps imem_req low while reset is held even though the state resets to FETCH.
    assign imem_req    = run_q && (state_q == S_FETCH);
    assign imem_addr   = pc_q;
    assign dmem_req    = mem_go;
    assign dmem_we     = mem_go && (opc == OPC_STORE);
    assign dmem_be     = mem_go ? be_w : 4'b0000;
    assign rf_we       = (state_q == S_WB) && (instr_q[11:7] != 5'd0);
    assign halted      = (state_q == S_HALT);
    assign trap        = trap_q;
    assign pc          = pc_q;
    assign instr       = instr_q;
    assign alu_op      = alu_op_q;
    assign alu_src_imm = alu_src_imm_q;
    assign imm         = imm_q;
    assign wb_sel      = wb_sel_q;

endmodule
